fpga_cfg_loader: RTL and testbench



---
 rtl/fpga_cfg_loader.sv | 138 +++++++++++++
 tb/tb_fpga_cfg_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: serialises a valid/ready bitstream MSB-first onto the CRAM scan chain
// Ports: clk, nrst (sync active-low); start/abort control; in_data/in_valid/in_ready word stream;
//        cfg_data/cfg_en/cfg_config_en registered chain drive; le_nrst fabric reset (released on done);
//        busy/done/error status. Optional CFG_LOADER_CRC_EN adds a CRC-16-CCITT trailer check.
module fpga_cfg_loader #(
    parameter int CHAIN_LEN  = 2304,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  cfg_data,
    output logic                  cfg_en,
    output logic                  cfg_config_en,
    output logic                  le_nrst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int NB_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
`ifdef CFG_LOADER_CRC_EN
    localparam int CW = (16 + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int TW = CW * DATA_WIDTH;
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE, ERROR, CRC_FETCH, CRC_CHECK} state_t;
    localparam state_t END_ST = CRC_FETCH;
    logic [15:0]   crc;
    logic [TW-1:0] trailer;
    logic [3:0]    ccnt;
    logic          error_r;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE, ERROR} state_t;
    localparam state_t END_ST = DONE;
`endif
    state_t state, next_state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      remain;
    logic [NB_W-1:0]       nleft;
    logic [NB_W-1:0]       nbits;
    logic go, last_bit, shift_en;

    assign remain   = LEN - count;
    assign nbits    = (remain < CNT_W'(DATA_WIDTH)) ? NB_W'(remain) : NB_W'(DATA_WIDTH);
    assign go       = start && !abort && (state == IDLE || state == DONE || state == ERROR);
    assign last_bit = state == SHIFT && nleft == NB_W'(1);
    assign shift_en = state == SHIFT && !abort;
    assign le_nrst  = done;

    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (busy && abort)                    next_state = IDLE;
        else if (go)                          next_state = FETCH;
        else if (state == FETCH && in_valid)  next_state = SHIFT;
        else if (last_bit)                    next_state = (count == LAST) ? END_ST : FETCH;
`ifdef CFG_LOADER_CRC_EN
        else if (state == CRC_FETCH && in_valid && ccnt == 4'(CW - 1)) next_state = CRC_CHECK;
        else if (state == CRC_CHECK)          next_state = (trailer[15:0] == crc) ? DONE : ERROR;
`endif
    end

    always_comb begin
`ifdef CFG_LOADER_CRC_EN
        in_ready = state == FETCH || state == CRC_FETCH;
        busy     = in_ready || state == SHIFT || state == CRC_CHECK;
`else
        in_ready = state == FETCH;
        busy     = in_ready || state == SHIFT;
`endif
    end

    // done waits one cycle after entering DONE so it never overlaps the final cfg_en pulse;
    // it drops on the same edge that a start leaves DONE.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            shreg         <= '0;
            count         <= '0;
            nleft         <= '0;
            cfg_data      <= 1'b0;
            cfg_en        <= 1'b0;
            cfg_config_en <= 1'b0;
            done          <= 1'b0;
        end else begin
            cfg_en        <= shift_en;
            cfg_config_en <= shift_en;
            cfg_data      <= shift_en & shreg[DATA_WIDTH-1];
            done          <= state == DONE && next_state == DONE;
            if (go) count <= '0;
            if (state == FETCH && in_valid) begin
                shreg <= in_data;
                nleft <= nbits;
            end
            if (state == SHIFT) begin
                shreg <= shreg << 1;
                count <= count + 1'b1;
                nleft <= nleft - NB_W'(1);
            end
        end
    end

`ifdef CFG_LOADER_CRC_EN
    assign error = error_r;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            crc     <= '0;
            trailer <= '0;
            ccnt    <= '0;
            error_r <= 1'b0;
        end else begin
            error_r <= state == ERROR && next_state == ERROR;
            if (go) begin
                crc  <= 16'hFFFF;
                ccnt <= '0;
            end
            if (state == SHIFT)
                crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ shreg[DATA_WIDTH-1]) ? 16'h1021 : 16'h0000);
            if (state == CRC_FETCH && in_valid) begin
                trailer <= TW'({trailer, in_data});
                ccnt    <= ccnt + 4'd1;
            end
        end
    end
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: directed self-checking bench for fpga_cfg_loader
module tb_fpga_cfg_loader;
`ifdef CFG_LOADER_CRC_EN
    localparam int LEN = 16;
`else
    localparam int LEN = 20;
`endif
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, cfg_data, cfg_en, cfg_config_en, le_nrst, busy, done, error;
    int         total = 0;
    int         bad = 0;
    int         en_cnt = 0;
    int         base = 0;
    logic [31:0] bits = '0;

    always #5 clk = ~clk;

    fpga_cfg_loader #(.CHAIN_LEN(LEN), .DATA_WIDTH(8)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_data(cfg_data), .cfg_en(cfg_en), .cfg_config_en(cfg_config_en),
        .le_nrst(le_nrst), .busy(busy), .done(done), .error(error)
    );

    // Chain-side observer: records every bit the chain would capture.
    always @(negedge clk) begin
        if (cfg_config_en) begin
            en_cnt = en_cnt + 1;
            bits = {bits[30:0], cfg_data};
        end
        if (nrst) begin
            total++;
            if (cfg_en !== cfg_config_en) begin
                bad++;
                $display("FAIL en_pair: cfg_en=%b cfg_config_en=%b", cfg_en, cfg_config_en);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] w, input int gap);
        int n = 0;
        while (!in_ready && n < 60) begin
            tick;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_wait: in_ready=%b required 1", in_ready);
        end
        for (int i = 0; i < gap; i++) begin
            tick;
            total++;
            if (cfg_config_en !== 1'b0) begin
                bad++;
                $display("FAIL gap_en: cfg_config_en=%b required 0", cfg_config_en);
            end
        end
        in_valid = 1'b1;
        in_data  = w;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_end;
        int n = 0;
        while (!(done || error) && n < 80) begin
            tick;
            n++;
        end
        if (!(done || error)) begin
            total++;
            bad++;
            $display("FAIL wait_end: done=%b error=%b required one high", done, error);
        end
    endtask

    task automatic check_load(input string name);
        total++;
        if (bits[19:0] !== 20'hA53CF) begin
            bad++;
            $display("FAIL %s_bits: got %h required a53cf", name, bits[19:0]);
        end
        total++;
        if (en_cnt - base !== 20) begin
            bad++;
            $display("FAIL %s_count: got %0d required 20", name, en_cnt - base);
        end
        total++;
        if ({done, le_nrst, busy, error} !== 4'b1100) begin
            bad++;
            $display("FAIL %s_status: done,le_nrst,busy,error=%b required 1100", name, {done, le_nrst, busy, error});
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        tick;
        tick;
        total++;
        if ({in_ready, cfg_data, cfg_en, cfg_config_en, le_nrst, busy, done, error} !== 8'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {in_ready, cfg_data, cfg_en, cfg_config_en, le_nrst, busy, done, error});
        end
        nrst = 1'b1;
        tick;
        tick;
        total++;
        if ({in_ready, busy, le_nrst} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: in_ready,busy,le_nrst=%b required 000", {in_ready, busy, le_nrst});
        end
    endtask

    task automatic test_basic;
        base = en_cnt;
        do_start;
        total++;
        if ({busy, in_ready, le_nrst, done} !== 4'b1100) begin
            bad++;
            $display("FAIL basic_fetch: busy,in_ready,le_nrst,done=%b required 1100", {busy, in_ready, le_nrst, done});
        end
        send(8'hA5, 0);
        send(8'h3C, 0);
        send(8'hF0, 0);
        wait_end;
        check_load("basic");
        tick;
        tick;
        tick;
        total++;
        if (en_cnt - base !== 20 || done !== 1'b1) begin
            bad++;
            $display("FAIL basic_hold: count=%0d done=%b required 20 and 1", en_cnt - base, done);
        end
    endtask

    task automatic test_backpressure;
        base = en_cnt;
        do_start;
        total++;
        if (done !== 1'b0 || le_nrst !== 1'b0) begin
            bad++;
            $display("FAIL restart_clear: done=%b le_nrst=%b required 0 0", done, le_nrst);
        end
        send(8'hA5, 0);
        send(8'h3C, 5);
        send(8'hF0, 0);
        wait_end;
        check_load("backpressure");
    endtask

    task automatic test_abort;
        base = en_cnt;
        do_start;
        send(8'hA5, 0);
        send(8'h3C, 0);
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        total++;
        if (cfg_config_en !== 1'b0 || cfg_en !== 1'b0) begin
            bad++;
            $display("FAIL abort_en: cfg_en=%b cfg_config_en=%b required 0 0", cfg_en, cfg_config_en);
        end
        total++;
        if (en_cnt - base !== 9) begin
            bad++;
            $display("FAIL abort_count: got %0d required 9", en_cnt - base);
        end
        total++;
        if ({busy, done, le_nrst, in_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_idle: busy,done,le_nrst,in_ready=%b required 0000", {busy, done, le_nrst, in_ready});
        end
        tick;
        tick;
        base = en_cnt;
        do_start;
        send(8'hA5, 0);
        send(8'h3C, 0);
        send(8'hF0, 0);
        wait_end;
        check_load("reload");
    endtask

    task automatic test_reset_mid;
        do_start;
        send(8'hA5, 0);
        tick;
        tick;
        tick;
        nrst = 1'b0;
        tick;
        nrst = 1'b1;
        total++;
        if ({in_ready, cfg_data, cfg_en, cfg_config_en, le_nrst, busy, done, error} !== 8'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got %b required 00000000",
                     {in_ready, cfg_data, cfg_en, cfg_config_en, le_nrst, busy, done, error});
        end
        tick;
        tick;
        tick;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: in_ready=%b busy=%b required 0 0", in_ready, busy);
        end
    endtask

    task automatic test_start_busy;
        base = en_cnt;
        do_start;
        send(8'hA5, 0);
        tick;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        send(8'h3C, 0);
        send(8'hF0, 0);
        wait_end;
        check_load("start_busy");
    endtask

    task automatic test_start_abort;
        do_start;
        send(8'hA5, 0);
        tick;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        total++;
        if ({busy, in_ready, cfg_config_en, done} !== 4'b0000) begin
            bad++;
            $display("FAIL start_abort: busy,in_ready,cfg_config_en,done=%b required 0000",
                     {busy, in_ready, cfg_config_en, done});
        end
        tick;
        tick;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_abort_idle: in_ready=%b busy=%b required 0 0", in_ready, busy);
        end
    endtask

`ifdef CFG_LOADER_CRC_EN
    task automatic test_crc;
        base = en_cnt;
        do_start;
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h1D, 0);
        send(8'h0F, 0);
        wait_end;
        total++;
        if ({done, error, le_nrst, busy} !== 4'b1010) begin
            bad++;
            $display("FAIL crc_good: done,error,le_nrst,busy=%b required 1010", {done, error, le_nrst, busy});
        end
        total++;
        if (en_cnt - base !== 16) begin
            bad++;
            $display("FAIL crc_count: got %0d required 16", en_cnt - base);
        end
        do_start;
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h1D, 0);
        send(8'h0E, 0);
        wait_end;
        total++;
        if ({done, error, le_nrst, busy} !== 4'b0100) begin
            bad++;
            $display("FAIL crc_bad: done,error,le_nrst,busy=%b required 0100", {done, error, le_nrst, busy});
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef CFG_LOADER_CRC_EN
        test_crc;
`else
        test_basic;
        test_backpressure;
        test_abort;
        test_reset_mid;
        test_start_busy;
        test_start_abort;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
